// File: rtl/result_capture_fifo_if.sv
// result_capture_fifo_if: capture-side strobe, consumer handshake and FIFO status bundle.
interface result_capture_fifo_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
);
  logic                       in_valid;
  logic [DATA_W-1:0]          in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic                       full;
  logic                       empty;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic                       clr_ovf;
  logic [CNT_W-1:0]           word_cnt;
  modport master (
    output in_valid, in_data, out_ready, clr_ovf,
    input  out_valid, out_data, full, empty, count, overflow, word_cnt
  );
  modport slave (
    input  in_valid, in_data, out_ready, clr_ovf,
    output out_valid, out_data, full, empty, count, overflow, word_cnt
  );
endinterface

// File: rtl/result_capture_fifo.sv
// result_capture_fifo: FWFT buffer for core results with sticky overflow and saturating accept count.
module result_capture_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  result_capture_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [AW:0]       count;
  logic [CNT_W-1:0]  word_cnt;
  logic              overflow, pop, push, drop, full, empty;
  always_comb begin
    empty = count == '0;
    full  = count == (AW+1)'(DEPTH);
    pop   = !empty && bus.out_ready;
    push  = bus.in_valid && (!full || pop);
    drop  = bus.in_valid && full && !pop;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
      // a drop in the same cycle as clr_ovf must not be lost
      overflow <= drop ? 1'b1 : bus.clr_ovf ? 1'b0 : overflow;
      if (push && !(&word_cnt)) word_cnt <= word_cnt + 1'b1;
    end
  end
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.word_cnt  = word_cnt;
endmodule

// File: tb/tb_result_capture_fifo.sv
// tb_result_capture_fifo: randomized and directed scoreboard bench against a queue-based model.
module tb_result_capture_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 8;
  localparam int WC_MAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  result_capture_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  result_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  logic [DATA_W-1:0] exp_q [$];
  bit  m_ovf;
  int  m_wc;
  bit  armed = 1'b0;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares DUT against the model mid-cycle and retires popped words
  always @(negedge clk) begin
    int m;
    logic [DATA_W-1:0] head;
    if (armed) begin
      m = exp_q.size();
      head = '0;
      if (m != 0) head = exp_q[0];
      chk("count", 64'(bus.count), 64'(m));
      chk("empty", 64'(bus.empty), 64'(m == 0));
      chk("full", 64'(bus.full), 64'(m == DEPTH));
      chk("out_valid", 64'(bus.out_valid), 64'(m != 0));
      chk("out_data", 64'(bus.out_data), 64'(head));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
      chk("word_cnt", 64'(bus.word_cnt), 64'(m_wc));
      if (m != 0 && bus.out_ready && !rst) void'(exp_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic c);
    int m;
    bit pop, push, drop;
    m = exp_q.size();
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.clr_ovf   = c;
    pop  = (m != 0) && r;
    push = v && (m < DEPTH || pop);
    drop = v && (m == DEPTH) && !pop;
    @(posedge clk);
    if (push) begin
      exp_q.push_back(d);
      if (m_wc < WC_MAX) m_wc++;
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hBAD0BAD0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    @(posedge clk);
    exp_q.delete();
    m_ovf = 1'b0;
    m_wc  = 0;
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    armed = 1'b1;
  endtask

  initial begin
    do_reset();
    step(1, 32'hA0000001, 0, 0);
    step(1, 32'hA0000002, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 32'(i), 0, 0);
    step(1, 32'h0000DEAD, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 32'h11111111, 1, 0);
    repeat (9) step(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) step(1, 32'h50000000 + 32'(k * 16 + i), 0, 0);
      repeat (5) step(0, 0, 1, 0);
    end
    for (int i = 0; i < 8; i++) step(1, 32'h60000000 + 32'(i), 0, 0);
    step(1, 32'h0BADF00D, 0, 0);
    step(1, 32'h0BADF00E, 0, 1);
    step(0, 0, 0, 1);
    repeat (5) step(0, 0, 1, 0);
    do_reset();
    step(0, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, $urandom, 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1) == 1,
                $urandom_range(0, 15) == 0);
    end
    repeat (DEPTH + 2) step(0, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
